// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the shared 8-bit uio pin bank,
// with a tristated turnaround cycle before every new grant.
module uio_bus_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned MAX_HOLD = 8,
   parameter logic [7:0]  OE_MASK  = 8'hFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   wr,
   input  logic [NREQ*8-1:0] wdata,
   output logic [NREQ-1:0]   grant,
   output logic [7:0]        rdata,
   output logic              rd_valid,
   output logic              busy,
   input  logic [7:0]        uio_in,
   output logic [7:0]        uio_out,
   output logic [7:0]        uio_oe
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, TURN, OWN} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   win_q, win_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic            dir_q, dir_d;
   logic [7:0]      hold_q, hold_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [7:0]      out_q, out_d;
   logic [7:0]      oe_q, oe_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            rv_q, rv_d;

   logic [IW-1:0]   pick;
   logic            any_req;
   logic            own_req;
   logic            release_own;
   logic [7:0]      wdata_w;

   function automatic logic [IW-1:0] wrap_inc(
      input logic [IW-1:0] v,
      input int unsigned   k
   );
      int unsigned s;
      s = 32'(v) + k;
      if (s >= NREQ) s = s - NREQ;
      return IW'(s);
   endfunction

   // first requester at or after the pointer wins
   always_comb begin
      pick    = rr_ptr_q;
      any_req = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any_req && req[wrap_inc(rr_ptr_q, k)]) begin
            pick    = wrap_inc(rr_ptr_q, k);
            any_req = 1'b1;
         end
      end
   end

   assign own_req     = req[win_q];
   assign wdata_w     = wdata[{win_q, 3'b000} +: 8];
   assign release_own = !own_req || !ena ||
                        (hold_q == 8'(MAX_HOLD));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ena && any_req) state_d = TURN;
         TURN:    state_d = (ena && own_req) ? OWN : IDLE;
         OWN:     if (release_own) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      win_d    = win_q;
      dir_d    = dir_q;
      rr_ptr_d = rr_ptr_q;
      hold_d   = hold_q;
      grant_d  = grant_q;
      out_d    = out_q;
      oe_d     = oe_q;
      rdata_d  = rdata_q;
      rv_d     = rv_q;
      case (state_q)
         IDLE: begin
            if (ena && any_req) begin
               win_d = pick;
               dir_d = wr[pick];
            end
         end
         TURN: begin
            if (state_d == OWN) begin
               grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
               hold_d  = 8'd1;
               if (dir_q) begin
                  out_d = wdata_w;
                  oe_d  = OE_MASK;
               end
            end
         end
         OWN: begin
            if (release_own) begin
               grant_d  = '0;
               oe_d     = '0;
               rv_d     = 1'b0;
               rr_ptr_d = wrap_inc(win_q, 1);
            end else begin
               hold_d = hold_q + 8'd1;
               if (dir_q) begin
                  out_d = wdata_w;
                  oe_d  = OE_MASK;
               end else begin
                  rdata_d = uio_in;
                  rv_d    = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q    <= '0;
         dir_q    <= 1'b0;
         rr_ptr_q <= '0;
         hold_q   <= '0;
         grant_q  <= '0;
         out_q    <= '0;
         oe_q     <= '0;
         rdata_q  <= '0;
         rv_q     <= 1'b0;
      end else begin
         win_q    <= win_d;
         dir_q    <= dir_d;
         rr_ptr_q <= rr_ptr_d;
         hold_q   <= hold_d;
         grant_q  <= grant_d;
         out_q    <= out_d;
         oe_q     <= oe_d;
         rdata_q  <= rdata_d;
         rv_q     <= rv_d;
      end
   end

   assign grant    = grant_q;
   assign uio_out  = out_q;
   assign uio_oe   = oe_q;
   assign rdata    = rdata_q;
   assign rd_valid = rv_q;
   assign busy     = (state_q != IDLE);

endmodule
